// File: rtl/rr_arb_mux_pkg.sv
// ============================================================================
//  rr_arb_mux_pkg
//  Types shared by rr_arb_mux and its sub-module.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

`include "rr_arb_mux_defs.vh"

package rr_arb_mux_pkg;

    // Output buffer occupancy.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // Packet lock state (only used when locking is compiled in).
    typedef enum logic {
        LK_UNLOCKED = `RR_LOCK_UNLOCKED,
        LK_LOCKED   = `RR_LOCK_LOCKED
    } lock_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb_mux_defs.vh
// ============================================================================
//  rr_arb_mux_defs.vh
//  Shared definitions for the round-robin arbitrating mux family:
//  index-width macro, channel-count limit and lock state encodings.
//  Rev 1.0 - initial release
// ============================================================================
`ifndef RR_ARB_MUX_DEFS_VH
`define RR_ARB_MUX_DEFS_VH

// Index width with a floor of 1 so a single-channel build still has a port.
`define RR_CLOG2_MIN1(n) (((n) > 1) ? $clog2(n) : 1)

// Largest supported channel count.
`define RR_NUM_CH_MAX 16

// Lock state encodings.
`define RR_LOCK_UNLOCKED 1'b0
`define RR_LOCK_LOCKED   1'b1

`endif

// File: rtl/rr_arb_mux_priority_pick.sv
// ============================================================================
//  rr_priority_pick
//  Combinational rotating-priority picker: finds the first set request bit
//  starting at ptr and wrapping modulo N. Returns one-hot grant, encoded
//  index and an any-request flag.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Two ascending passes: first channels at or above ptr, then the wrap
    // from channel 0. The first hit wins, giving rotating priority.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i]) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = IW'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_arb_mux.sv
// ============================================================================
//  rr_arb_mux
//  N-channel registered selector with round-robin arbitration and
//  valid/ready handshakes on all inputs and the output. One-entry output
//  buffer, one cycle latency, full throughput.
//  Optional: RR_ARB_MUX_LOCK_EN adds in_last and holds the grant on a channel
//  until its last beat is accepted.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

`include "rr_arb_mux_defs.vh"

module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 2,
    parameter int IDX_W  = `RR_CLOG2_MIN1(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
`ifdef RR_ARB_MUX_LOCK_EN
    input  logic [NUM_CH-1:0]       in_last,
`endif
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [IDX_W-1:0]        out_ch,
    input  logic                    out_ready
);

    generate
        if (NUM_CH < 1 || NUM_CH > `RR_NUM_CH_MAX) begin : g_bad_num_ch
            $error("rr_arb_mux: NUM_CH out of range");
        end
    endgenerate

    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_gnt_oh;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic              w_any;
    logic              w_space;
    logic              w_accept;
    logic              w_last;
    logic [IDX_W-1:0]  w_ptr_next;
    logic [WIDTH-1:0]  w_sel_data;

    logic [IDX_W-1:0]  r_ptr;
    logic [WIDTH-1:0]  r_data;
    logic [IDX_W-1:0]  r_ch;
    buf_state_t        r_state;
    buf_state_t        w_state_next;

`ifdef RR_ARB_MUX_LOCK_EN
    lock_state_t       r_lock;
    logic [IDX_W-1:0]  r_lock_ch;

    // While locked only the owning channel may be granted.
    assign w_req  = (r_lock == LK_LOCKED) ?
                    (in_valid & (NUM_CH'(1) << r_lock_ch)) : in_valid;
    assign w_last = in_last[w_gnt_idx];
`else
    assign w_req  = in_valid;
    assign w_last = 1'b1;
`endif

    rr_priority_pick #(
        .N  (NUM_CH),
        .IW (IDX_W)
    ) u_pick (
        .req (w_req),
        .ptr (r_ptr),
        .gnt (w_gnt_oh),
        .idx (w_gnt_idx),
        .any (w_any)
    );

    // Buffer can take a beat when empty or when it drains this cycle.
    assign w_space   = (r_state == BUF_EMPTY) || out_ready;
    assign w_accept  = w_any && w_space && !rst;
    assign in_ready  = (w_space && !rst) ? w_gnt_oh : '0;
    assign w_ptr_next = (w_gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : (w_gnt_idx + IDX_W'(1));

    assign out_valid = (r_state == BUF_FULL);
    assign out_data  = r_data;
    assign out_ch    = r_ch;

    // Data mux driven by the one-hot grant.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt_oh[i]) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output buffer next state: accept always fills, drain alone empties.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BUF_EMPTY: if (w_accept) w_state_next = BUF_FULL;
            BUF_FULL: begin
                if (w_accept)       w_state_next = BUF_FULL;
                else if (out_ready) w_state_next = BUF_EMPTY;
            end
            default: w_state_next = BUF_EMPTY;
        endcase
    end

    // Output buffer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= BUF_EMPTY;
        else     r_state <= w_state_next;
    end

    // Beat payload and source index; held across drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_ch   <= '0;
        end else if (w_accept) begin
            r_data <= w_sel_data;
            r_ch   <= w_gnt_idx;
        end
    end

    // Priority pointer moves past the winner only when a packet completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_ptr <= '0;
        else if (w_accept && w_last) r_ptr <= w_ptr_next;
    end

`ifdef RR_ARB_MUX_LOCK_EN
    // Lock onto a channel while it sends non-last beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock    <= LK_UNLOCKED;
            r_lock_ch <= '0;
        end else if (w_accept) begin
            r_lock    <= w_last ? LK_UNLOCKED : LK_LOCKED;
            r_lock_ch <= w_gnt_idx;
        end
    end
`endif

endmodule

`default_nettype wire
